// File: rtl/npu_stream_sequencer_if.sv
// Handshake and data bus between the stream sequencer, its memories and the npu FIFOs.
interface npu_stream_sequencer_if #(
  parameter int CFG_AW = 11,
  parameter int IN_AW  = 19,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CFG_AW-1:0] cfg_rom_addr;
  logic [31:0]       cfg_rom_data;
  logic [IN_AW-1:0]  in_mem_addr;
  logic [31:0]       in_mem_data;
  logic [25:0]       npu_config_data;
  logic              npu_config_fifo_write_enable;
  logic              npu_config_fifo_full;
  logic [31:0]       npu_input_data;
  logic              npu_input_fifo_write_enable;
  logic              npu_input_fifo_full;
  logic [31:0]       npu_output_data;
  logic              npu_output_fifo_empty;
  logic              npu_output_fifo_read_enable;
  logic [31:0]       result_data;
  logic              result_valid;
  logic [CNT_W-1:0]  results_count;
  logic              busy;
  logic              done;
  logic              overflow_err;

  modport master (
    input  start, cfg_rom_data, in_mem_data, npu_config_fifo_full,
           npu_input_fifo_full, npu_output_data, npu_output_fifo_empty,
    output cfg_rom_addr, in_mem_addr, npu_config_data, npu_config_fifo_write_enable,
           npu_input_data, npu_input_fifo_write_enable, npu_output_fifo_read_enable,
           result_data, result_valid, results_count, busy, done, overflow_err
  );

  modport slave (
    output start, cfg_rom_data, in_mem_data, npu_config_fifo_full,
           npu_input_fifo_full, npu_output_data, npu_output_fifo_empty,
    input  cfg_rom_addr, in_mem_addr, npu_config_data, npu_config_fifo_write_enable,
           npu_input_data, npu_input_fifo_write_enable, npu_output_fifo_read_enable,
           result_data, result_valid, results_count, busy, done, overflow_err
  );
endinterface

// File: rtl/npu_stream_sequencer.sv
// Streams config ROM then input memory into the npu FIFOs while draining npu results.
module npu_stream_sequencer #(
  parameter int CONFIG_WORDS     = 605,
  parameter int INPUT_WORDS      = 36,
  parameter int OUTPUTS_EXPECTED = 4,
  parameter int CFG_AW           = 11,
  parameter int IN_AW            = 19,
  parameter int CNT_W            = 8
) (
  input logic                    CLK,
  input logic                    RST,
  npu_stream_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_RD, S_CFG_WR, S_IN_RD, S_IN_WR, S_DRAIN, S_DONE
  } state_t;

  localparam logic [CFG_AW-1:0] CFG_LAST = CFG_AW'(CONFIG_WORDS - 1);
  localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(INPUT_WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(OUTPUTS_EXPECTED);

  state_t            state_q, state_d;
  logic [CFG_AW-1:0] cfg_addr_q, cfg_addr_d;
  logic [IN_AW-1:0]  in_addr_q, in_addr_d;
  logic              cfg_we, in_we, rd_en, run_start;
  logic              rd_pend_q;
  logic [31:0]       result_data_q;
  logic              result_valid_q;
  logic [CNT_W-1:0]  count_q;
  logic              ovf_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      cfg_addr_q <= '0;
      in_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      cfg_addr_q <= cfg_addr_d;
      in_addr_q  <= in_addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cfg_addr_d = cfg_addr_q;
    in_addr_d  = in_addr_q;
    cfg_we     = 1'b0;
    in_we      = 1'b0;
    run_start  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d    = S_CFG_RD;
          cfg_addr_d = '0;
          run_start  = 1'b1;
        end
      end
      S_CFG_RD: state_d = S_CFG_WR;
      S_CFG_WR: begin
        // Full holds both address and ROM data, so the word is retried unchanged.
        cfg_we = ~bus.npu_config_fifo_full;
        if (!bus.npu_config_fifo_full) begin
          if (cfg_addr_q == CFG_LAST) begin
            state_d   = S_IN_RD;
            in_addr_d = '0;
          end else begin
            cfg_addr_d = cfg_addr_q + 1'b1;
            state_d    = S_CFG_RD;
          end
        end
      end
      S_IN_RD: state_d = S_IN_WR;
      S_IN_WR: begin
        in_we = ~bus.npu_input_fifo_full;
        if (!bus.npu_input_fifo_full) begin
          if (in_addr_q == IN_LAST) begin
            state_d = S_DRAIN;
          end else begin
            in_addr_d = in_addr_q + 1'b1;
            state_d   = S_IN_RD;
          end
        end
      end
      S_DRAIN: if (count_q == CNT_MAX) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_en = ~bus.npu_output_fifo_empty & (state_q != S_IDLE);

  // Read data lands one cycle after the strobe; capture it on that edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_pend_q      <= 1'b0;
      result_data_q  <= '0;
      result_valid_q <= 1'b0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
    end else begin
      rd_pend_q      <= rd_en;
      result_valid_q <= rd_pend_q;
      if (rd_pend_q) result_data_q <= bus.npu_output_data;
      if (run_start) begin
        count_q <= '0;
        ovf_q   <= 1'b0;
      end else if (rd_pend_q) begin
        if (count_q == CNT_MAX) ovf_q <= 1'b1;
        else                    count_q <= count_q + 1'b1;
      end
    end
  end

  assign bus.cfg_rom_addr                 = cfg_addr_q;
  assign bus.in_mem_addr                  = in_addr_q;
  assign bus.npu_config_data              = bus.cfg_rom_data[25:0];
  assign bus.npu_config_fifo_write_enable = cfg_we;
  assign bus.npu_input_data               = bus.in_mem_data;
  assign bus.npu_input_fifo_write_enable  = in_we;
  assign bus.npu_output_fifo_read_enable  = rd_en;
  assign bus.result_data                  = result_data_q;
  assign bus.result_valid                 = result_valid_q;
  assign bus.results_count                = count_q;
  assign bus.busy                         = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done                         = (state_q == S_DONE);
  assign bus.overflow_err                 = ovf_q;

endmodule
